// File: rtl/si_fetch_pkg.sv
// Shared types and constants for the si_fetch instruction fetch unit.
package si_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam int unsigned PC_INC      = 4;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned CNT_W       = 2;

endpackage

// File: rtl/si_fetch_queue.sv
// Two-entry registered FIFO of {instruction, pc} between fetch and decode.
// Entry 0 is always the head; a pop shifts entry 1 down.
module si_fetch_queue
    import si_fetch_pkg::*;
#(
    parameter int unsigned INST_DW = 32,
    parameter int unsigned INST_AW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [INST_DW-1:0] push_inst,
    input  logic [INST_AW-1:0] push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               head_valid,
    output logic [INST_DW-1:0] head_inst,
    output logic [INST_AW-1:0] head_pc
);

    logic [INST_DW-1:0] inst0, inst1;
    logic [INST_AW-1:0] pc0, pc1;

    // Flush wins over push/pop: a same-cycle pop is already consumed and a push is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            inst0 <= '0;
            inst1 <= '0;
            pc0   <= '0;
            pc1   <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == '0) begin
                        inst0 <= push_inst;
                        pc0   <= push_pc;
                    end else begin
                        inst1 <= push_inst;
                        pc1   <= push_pc;
                    end
                    if (count < CNT_W'(QUEUE_DEPTH))
                        count <= count + 1'b1;
                end
                2'b01: begin
                    inst0 <= inst1;
                    pc0   <= pc1;
                    count <= count - 1'b1;
                end
                2'b11: begin
                    if (count == CNT_W'(1)) begin
                        inst0 <= push_inst;
                        pc0   <= push_pc;
                    end else begin
                        inst0 <= inst1;
                        pc0   <= pc1;
                        inst1 <= push_inst;
                        pc1   <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_inst  = inst0;
    assign head_pc    = pc0;

endmodule

// File: rtl/si_fetch.sv
// Instruction fetch unit: PC, single-outstanding imem request FSM, ALU redirect handling.
// Optional SI_FETCH_MISALIGN_CHK_EN adds sticky misalign_o and halts fetch on misaligned redirect.
module si_fetch
    import si_fetch_pkg::*;
#(
    parameter int unsigned         INST_DW  = 32,
    parameter int unsigned         INST_AW  = 32,
    parameter logic [INST_AW-1:0]  PC_START = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid_o,
    output logic [INST_AW-1:0] imem_req_addr_o,
    input  logic               imem_req_ready_i,
    input  logic               imem_rsp_valid_i,
    input  logic [INST_DW-1:0] imem_rsp_data_i,
    output logic               inst_valid_o,
    output logic [INST_DW-1:0] inst_o,
    output logic [INST_AW-1:0] inst_pc_o,
    input  logic               inst_ready_i,
    input  logic               control_en_i,
    input  logic [INST_AW-1:0] control_pc_i
`ifdef SI_FETCH_MISALIGN_CHK_EN
    ,
    output logic               misalign_o
`endif
);

    state_t             state, state_next;
    logic [INST_AW-1:0] pc, pc_next;
    logic [INST_AW-1:0] req_pc, req_pc_next;
    logic [CNT_W-1:0]   q_count;
    logic               q_push, q_pop, q_flush;
    logic               accept;
    logic               halt;

`ifdef SI_FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (control_en_i && (control_pc_i[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end

    assign misalign_o = misalign_q;
    assign halt       = misalign_q;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^control_pc_i[1:0];
    assign halt          = 1'b0;
`endif

    assign imem_req_valid_o = (state == S_REQ) && (q_count < CNT_W'(QUEUE_DEPTH)) && !halt;
    assign imem_req_addr_o  = pc;
    assign accept           = imem_req_valid_o && imem_req_ready_i;
    assign q_pop            = inst_valid_o && inst_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= PC_START;
            req_pc <= PC_START;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        q_push      = 1'b0;
        q_flush     = 1'b0;

        unique case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (accept) begin
                    pc_next     = pc + INST_AW'(PC_INC);
                    req_pc_next = pc;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    q_push     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid_i)
                    state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase

        // Redirect overrides the normal step: any in-flight request now belongs to the squashed path.
        if (control_en_i) begin
            q_flush = 1'b1;
            q_push  = 1'b0;
            pc_next = {control_pc_i[INST_AW-1:2], 2'b00};
            unique case (state)
                S_REQ:   state_next = accept ? S_DROP : S_REQ;
                S_WAIT:  state_next = imem_rsp_valid_i ? S_REQ : S_DROP;
                S_DROP:  state_next = imem_rsp_valid_i ? S_REQ : S_DROP;
                default: state_next = S_REQ;
            endcase
        end
    end

    si_fetch_queue #(
        .INST_DW (INST_DW),
        .INST_AW (INST_AW)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_inst  (imem_rsp_data_i),
        .push_pc    (req_pc),
        .pop        (q_pop),
        .flush      (q_flush),
        .count      (q_count),
        .head_valid (inst_valid_o),
        .head_inst  (inst_o),
        .head_pc    (inst_pc_o)
    );

endmodule

// File: tb/tb_si_fetch.sv
// Table-driven directed bench for si_fetch, plus hand-written misalign and mid-run reset sequences.
module tb_si_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        ctl_en;
    logic [31:0] ctl_pc;
`ifdef SI_FETCH_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    si_fetch #(
        .INST_DW  (32),
        .INST_AW  (32),
        .PC_START (32'h8000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (req_valid),
        .imem_req_addr_o  (req_addr),
        .imem_req_ready_i (req_ready),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .inst_valid_o     (inst_valid),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .inst_ready_i     (inst_ready),
        .control_en_i     (ctl_en),
        .control_pc_i     (ctl_pc)
`ifdef SI_FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o       (misalign)
`endif
    );

    typedef struct {
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        irdy;
        logic        ctl;
        logic [31:0] cpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_chk;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                                input logic irdy, input logic ctl, input logic [31:0] cpc,
                                input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_chk);
        vec_t v;
        v.rdy = rdy; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.irdy = irdy; v.ctl = ctl; v.cpc = cpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
        v.e_chk = e_chk;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                         input logic irdy, input logic ctl, input logic [31:0] cpc);
        req_ready  = rdy;
        rsp_valid  = rsp_v;
        rsp_data   = rsp_d;
        inst_ready = irdy;
        ctl_en     = ctl;
        ctl_pc     = cpc;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " req_valid"}, {31'd0, req_valid}, 32'd0);
        chk({tag, " req_addr"}, req_addr, 32'h8000_0000);
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, " inst"}, inst, 32'd0);
        chk({tag, " inst_pc"}, inst_pc, 32'd0);
`ifdef SI_FETCH_MISALIGN_CHK_EN
        chk({tag, " misalign"}, {31'd0, misalign}, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with redirect and response both active: both must be ignored.
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 32'h1234_5678);
        repeat (3) @(negedge clk);
        chk_reset_values("reset");

        // Test 1: straight-line fetch; test 2: decode stall; test 3: redirect in S_WAIT;
        // test 5: wrap; test 4: redirect on accept / on response.
        add(1,0,32'h0,         1,0,32'h0,          0,32'h8000_0000,0,32'h0,        32'h0,        1);
        add(1,0,32'h0,         1,0,32'h0,          1,32'h8000_0000,0,32'h0,        32'h0,        0);
        add(1,1,32'hA000_0000, 1,0,32'h0,          0,32'h8000_0004,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         1,0,32'h0,          1,32'h8000_0004,1,32'hA000_0000,32'h8000_0000,1);
        add(1,1,32'hA000_0004, 1,0,32'h0,          0,32'h8000_0008,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         0,0,32'h0,          1,32'h8000_0008,1,32'hA000_0004,32'h8000_0004,1);
        add(1,1,32'hA000_0008, 0,0,32'h0,          0,32'h8000_000C,1,32'hA000_0004,32'h8000_0004,1);
        for (int i = 0; i < 8; i++)
            add(1,0,32'h0,     0,0,32'h0,          0,32'h8000_000C,1,32'hA000_0004,32'h8000_0004,1);
        add(1,0,32'h0,         1,0,32'h0,          0,32'h8000_000C,1,32'hA000_0004,32'h8000_0004,1);
        add(1,0,32'h0,         1,0,32'h0,          1,32'h8000_000C,1,32'hA000_0008,32'h8000_0008,1);
        add(1,0,32'h0,         1,1,32'h8000_0100,  0,32'h8000_0010,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         1,0,32'h0,          0,32'h8000_0100,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         1,0,32'h0,          0,32'h8000_0100,0,32'h0,        32'h0,        0);
        add(1,1,32'hDEAD_BEEF, 1,0,32'h0,          0,32'h8000_0100,0,32'h0,        32'h0,        0);
        add(0,0,32'h0,         1,1,32'hFFFF_FFFC,  1,32'h8000_0100,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         1,0,32'h0,          1,32'hFFFF_FFFC,0,32'h0,        32'h0,        0);
        add(1,1,32'hB000_FFFC, 1,0,32'h0,          0,32'h0000_0000,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         0,1,32'h8000_0200,  1,32'h0000_0000,1,32'hB000_FFFC,32'hFFFF_FFFC,1);
        add(1,1,32'hDEAD_0001, 1,0,32'h0,          0,32'h8000_0200,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         1,0,32'h0,          1,32'h8000_0200,0,32'h0,        32'h0,        0);
        add(1,1,32'hDEAD_0002, 1,1,32'h8000_0300,  0,32'h8000_0204,0,32'h0,        32'h0,        0);
        add(1,0,32'h0,         1,0,32'h0,          1,32'h8000_0300,0,32'h0,        32'h0,        0);
        add(1,1,32'hC000_0300, 1,0,32'h0,          0,32'h8000_0304,0,32'h0,        32'h0,        0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h8000_0304,1,32'hC000_0300,32'h8000_0300,1);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h8000_0304,0,32'h0,        32'h0,        0);

        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("r%0d req_valid", i), {31'd0, req_valid}, {31'd0, tbl[i].e_req});
            chk($sformatf("r%0d req_addr", i), req_addr, tbl[i].e_addr);
            chk($sformatf("r%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_iv});
            if (tbl[i].e_chk) begin
                chk($sformatf("r%0d inst", i), inst, tbl[i].e_inst);
                chk($sformatf("r%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
            end
            drive(tbl[i].rdy, tbl[i].rsp_v, tbl[i].rsp_d, tbl[i].irdy, tbl[i].ctl, tbl[i].cpc);
            @(negedge clk);
        end

        // Misaligned redirect target 8000_0102.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0102);
        @(negedge clk);
        chk("mis addr", req_addr, 32'h8000_0100);
`ifdef SI_FETCH_MISALIGN_CHK_EN
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mis halt%0d req_valid", i), {31'd0, req_valid}, 32'd0);
            chk($sformatf("mis halt%0d misalign", i), {31'd0, misalign}, 32'd1);
            @(negedge clk);
        end
`else
        chk("mis req_valid", {31'd0, req_valid}, 32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("mis wait req_valid", {31'd0, req_valid}, 32'd0);
        chk("mis wait addr", req_addr, 32'h8000_0104);
        drive(1'b1, 1'b1, 32'hE000_0100, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("mis word valid", {31'd0, inst_valid}, 32'd1);
        chk("mis word inst", inst, 32'hE000_0100);
        chk("mis word pc", inst_pc, 32'h8000_0100);
        chk("mis next addr", req_addr, 32'h8000_0104);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
`endif

        // Mid-run reset returns every output to its reset value on the next cycle.
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("midrst");
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("post rst idle req_valid", {31'd0, req_valid}, 32'd0);
        @(negedge clk);
        chk("post rst req_valid", {31'd0, req_valid}, 32'd1);
        chk("post rst addr", req_addr, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
